// File: rtl/bkp_cfg_pkg.sv
// Shared types and constants for the BkpCfg core-side responder.
package bkp_cfg_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Classification of a latched request.
  typedef enum logic [1:0] {
    KIND_DATA   = 2'd0,
    KIND_COMMIT = 2'd1,
    KIND_BAD    = 2'd2
  } kind_e;

  // Bit positions inside the BK status word.
  localparam int ST_BUSY    = 0;
  localparam int ST_ACK     = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_PEND    = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_IDX_LSB = 16;

  // Index that requests the shadow-to-active copy.
  localparam logic [31:0] DEF_COMMIT_IDX = 32'hFFFF_FFFF;

  // Assemble the status word; bits [7:4] are always zero.
  function automatic logic [31:0] pack_status(input logic        busy,
                                              input logic        ack,
                                              input logic        err,
                                              input logic        pend,
                                              input logic [7:0]  cnt,
                                              input logic [15:0] last);
    logic [31:0] s;
    s                     = '0;
    s[ST_BUSY]            = busy;
    s[ST_ACK]             = ack;
    s[ST_ERR]             = err;
    s[ST_PEND]            = pend;
    s[ST_CNT_LSB +: 8]    = cnt;
    s[ST_IDX_LSB +: 16]   = last;
    return s;
  endfunction

endpackage

// File: rtl/bkp_cfg_bank.sv
// Shadow and active config register banks: single write port into the
// shadow bank, atomic copy of the whole shadow bank into the active bank.
module bkp_cfg_bank #(
  parameter int          NUM_REGS = 16,
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_commit,
  output logic [NUM_REGS*32-1:0] o_active
);

  logic [31:0] r_shadow [NUM_REGS];
  logic [31:0] r_active [NUM_REGS];

  // Shadow writes and shadow-to-active commit; both banks reset to RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_shadow[k] <= RST_VAL;
        r_active[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
          r_shadow[k] <= i_wr_data;
        end
      end
      if (i_commit) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          r_active[k] <= r_shadow[k];
        end
      end
    end
  end

  // Flatten the active bank; reg k sits at bits [32k+31:32k].
  always_comb begin
    o_active = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_active[k*32 +: 32] = r_active[k];
    end
  end

endmodule

// File: rtl/bkp_cfg_sink.sv
// Core-side responder for the BkpCfg level handshake. One index/value write
// is taken per Ready rising edge; a commit index copies shadow to active.
module bkp_cfg_sink
  import bkp_cfg_pkg::*;
#(
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] COMMIT_IDX = DEF_COMMIT_IDX,
  parameter logic [31:0] RST_VAL    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   BkpCfg_Ready_i,
  input  logic [31:0]            BkpCfg_DataIndex_i,
  input  logic [31:0]            BkpCfg_DataValue_i,
  output logic [31:0]            BK_Status_o,
  output logic [NUM_REGS*32-1:0] cfg_regs_o,
  output logic                   cfg_commit_o,
  output logic                   cfg_wr_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_ready_q;
  logic        w_rise;
  kind_e       w_kind;
  kind_e       r_kind;
  logic [15:0] r_idx;
  logic [31:0] r_val;
  logic        r_err;
  logic        r_pend;
  logic [7:0]  r_cnt;
  logic [15:0] r_last;
  logic [31:0] r_status;
  logic        w_err_nxt;
  logic        w_pend_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] w_last_nxt;
  logic        w_wr_en;
  logic        w_commit;

  assign w_rise = BkpCfg_Ready_i & ~r_ready_q;

  // Classify the incoming index: data register, commit request, or bad.
  always_comb begin
    w_kind = KIND_BAD;
    if (BkpCfg_DataIndex_i < 32'(NUM_REGS)) begin
      w_kind = KIND_DATA;
    end else if (BkpCfg_DataIndex_i == COMMIT_IDX) begin
      w_kind = KIND_COMMIT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a rise is only honoured in IDLE, so a request still
  // held high after HOLD cannot be taken twice.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_nxt = LATCH;
      LATCH:   w_state_nxt = WRITE;
      WRITE:   w_state_nxt = HOLD;
      HOLD:    if (!BkpCfg_Ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: write/commit strobes fire only in WRITE.
  always_comb begin
    w_wr_en  = 1'b0;
    w_commit = 1'b0;
    if (r_state == WRITE) begin
      w_wr_en  = (r_kind == KIND_DATA);
      w_commit = (r_kind == KIND_COMMIT);
    end
  end

  assign cfg_wr_o     = w_wr_en;
  assign cfg_commit_o = w_commit;

  // Next values of the status fields, resolved in WRITE.
  always_comb begin
    w_err_nxt  = r_err;
    w_pend_nxt = r_pend;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    if (r_state == WRITE) begin
      w_last_nxt = r_idx;
      case (r_kind)
        KIND_DATA: begin
          w_cnt_nxt  = r_cnt + 8'd1;
          w_pend_nxt = 1'b1;
        end
        KIND_COMMIT: begin
          w_pend_nxt = 1'b0;
          w_err_nxt  = 1'b0;
        end
        default: w_err_nxt = 1'b1;
      endcase
    end
  end

  // Request capture in LATCH; only reachable through LATCH, so no reset.
  always_ff @(posedge clk) begin
    if (r_state == LATCH) begin
      r_idx  <= BkpCfg_DataIndex_i[15:0];
      r_val  <= BkpCfg_DataValue_i;
      r_kind <= w_kind;
    end
  end

  // Edge detect, sticky flags, counters and the registered status word.
  // Status is built from next-state values so it lines up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready_q <= 1'b0;
      r_err     <= 1'b0;
      r_pend    <= 1'b0;
      r_cnt     <= 8'd0;
      r_last    <= 16'd0;
      r_status  <= 32'd0;
    end else begin
      r_ready_q <= BkpCfg_Ready_i;
      r_err     <= w_err_nxt;
      r_pend    <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_status  <= pack_status(w_state_nxt != IDLE, w_state_nxt == HOLD,
                               w_err_nxt, w_pend_nxt, w_cnt_nxt, w_last_nxt);
    end
  end

  assign BK_Status_o = r_status;

  bkp_cfg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .RST_VAL  (RST_VAL)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx[IDX_W-1:0]),
    .i_wr_data (r_val),
    .i_commit  (w_commit),
    .o_active  (cfg_regs_o)
  );

endmodule

// File: tb/tb_bkp_cfg_sink.sv
// Self-checking bench for bkp_cfg_sink: transaction-timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bkp_cfg_sink;

  localparam int NR = 16;
  localparam logic [31:0] CIDX = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic [31:0]   idx = 32'd0;
  logic [31:0]   val = 32'd0;
  logic [31:0]   status;
  logic [NR*32-1:0] regs;
  logic          commit;
  logic          wr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bkp_cfg_sink #(.NUM_REGS(NR), .COMMIT_IDX(CIDX), .RST_VAL(32'h0)) dut (
    .clk                (clk),
    .rst                (rst),
    .BkpCfg_Ready_i     (rdy),
    .BkpCfg_DataIndex_i (idx),
    .BkpCfg_DataValue_i (val),
    .BK_Status_o        (status),
    .cfg_regs_o         (regs),
    .cfg_commit_o       (commit),
    .cfg_wr_o           (wr)
  );

  task automatic chk(input string name, input logic [NR*32-1:0] act,
                     input logic [NR*32-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since the Ready rise (-1 = no
  // transaction). Effects land at the end of cycle 2; ack from cycle 3.
  int          m_t = -1;
  bit          m_valid = 1'b0;
  logic        m_prev = 1'b0;
  logic [31:0] m_idx = 32'd0;
  logic [31:0] m_val = 32'd0;
  logic [31:0] m_sh  [NR];
  logic [31:0] m_act [NR];
  logic        m_err = 1'b0;
  logic        m_pend = 1'b0;
  logic [7:0]  m_cnt = 8'd0;
  logic [15:0] m_last = 16'd0;
  logic [NR*32-1:0] m_flat;
  logic [31:0] m_stat;

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < NR; k++) m_flat[k*32 +: 32] = m_act[k];
      m_stat = {m_last, m_cnt, 4'b0000, m_pend, m_err, (m_t >= 3), (m_t >= 1)};
      chk("cfg_wr_o", {511'd0, wr}, {511'd0, (m_t == 2) && (m_idx < NR)});
      chk("cfg_commit_o", {511'd0, commit}, {511'd0, (m_t == 2) && (m_idx == CIDX)});
      chk("BK_Status_o", {480'd0, status}, {480'd0, m_stat});
      chk("cfg_regs_o", regs, m_flat);
    end
    if (rst) begin
      m_t = -1; m_prev = 1'b0; m_err = 1'b0; m_pend = 1'b0;
      m_cnt = 8'd0; m_last = 16'd0;
      for (int k = 0; k < NR; k++) begin m_sh[k] = 32'd0; m_act[k] = 32'd0; end
      m_valid = 1'b1;
    end else begin
      if (m_t == -1) begin
        if (rdy && !m_prev) m_t = 1;
      end else if (m_t == 1) begin
        m_idx = idx; m_val = val; m_t = 2;
      end else if (m_t == 2) begin
        m_last = m_idx[15:0];
        if (m_idx < NR) begin
          m_sh[m_idx[3:0]] = m_val; m_cnt = m_cnt + 8'd1; m_pend = 1'b1;
        end else if (m_idx == CIDX) begin
          for (int k = 0; k < NR; k++) m_act[k] = m_sh[k];
          m_pend = 1'b0; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_t = 3;
      end else begin
        if (!rdy) m_t = -1;
      end
      m_prev = rdy;
    end
  end

  // One handshake: raise Ready for 'hold' cycles, drop it, let the FSM settle.
  task automatic txn(input logic [31:0] i, input logic [31:0] v, input int hold);
    @(posedge clk); #1 idx = i; val = v; rdy = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  logic [NR*32-1:0] mask2;
  int sel;

  initial begin
    mask2 = '1;
    mask2[2*32 +: 32] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset status", {480'd0, status}, 512'd0);
    chk("reset regs", regs, 512'd0);
    chk("reset pulses", {510'd0, wr, commit}, 512'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Data write: shadow only, active untouched
    txn(32'd2, 32'hDEAD_BEEF, 3);
    chk("write status", {480'd0, status}, {480'd0, 32'h0002_0108});
    chk("write reg2 inactive", {480'd0, regs[2*32 +: 32]}, 512'd0);

    // Commit copies shadow to active
    txn(CIDX, 32'h1234_5678, 2);
    chk("commit status", {480'd0, status}, {480'd0, 32'hFFFF_0100});
    chk("commit reg2", {480'd0, regs[2*32 +: 32]}, {480'd0, 32'hDEAD_BEEF});
    chk("commit others", regs & mask2, 512'd0);

    // Bad index sets sticky err; next commit clears it
    txn(32'd16, 32'h55, 2);
    chk("bad status", {480'd0, status}, {480'd0, 32'h0010_0104});
    txn(CIDX, 32'h0, 2);
    chk("err cleared", {480'd0, status}, {480'd0, 32'hFFFF_0100});

    // One-cycle Ready pulse
    @(posedge clk); #1 idx = 32'd8; val = 32'h0800_0008; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pulse wr at N+2", {511'd0, wr}, {511'd0, 1'b1});
    @(posedge clk); @(negedge clk);
    chk("pulse ack at N+3", {511'd0, status[1]}, {511'd0, 1'b1});
    @(posedge clk); @(negedge clk);
    chk("pulse busy N+4", {510'd0, status[1:0]}, 512'd0);
    chk("pulse status", {480'd0, status}, {480'd0, 32'h0008_0208});

    // Reset during WRITE, Ready still high at release
    @(posedge clk); #1 idx = 32'd5; val = 32'h5555_5555; rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid-reset status", {480'd0, status}, 512'd0);
    chk("mid-reset regs", regs, 512'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1 rdy = 1'b0;
    repeat (6) @(posedge clk); @(negedge clk);
    chk("post-reset write", {480'd0, status}, {480'd0, 32'h0005_0108});

    // wr_cnt wrap
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 256; n++)
      txn(32'($urandom_range(0, NR-1)), $urandom, int'($urandom_range(1, 3)));
    chk("wr_cnt wrap", {504'd0, status[15:8]}, 512'd0);
    txn(32'd3, 32'h0303_0303, 1);
    chk("wr_cnt 257", {504'd0, status[15:8]}, {504'd0, 8'd1});

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) < 2);
      if (!rdy) begin
        sel = int'($urandom_range(0, 9));
        if (sel <= 5)      idx = 32'($urandom_range(0, NR-1));
        else if (sel <= 7) idx = CIDX;
        else if (sel == 8) idx = 32'($urandom_range(NR, NR+100));
        else               idx = $urandom;
        val = $urandom;
      end
      rdy = ($urandom_range(0, 99) < 55);
    end
    @(posedge clk); #1 rst = 1'b0; rdy = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
